// File: rtl/zero_counter_seq.sv
// zero_counter_seq: sequential bit-statistic engine.
// Accepts one IN_W-bit word per in_valid/in_ready handshake and scans it
// CHUNK_W bits per clock. It returns the zero count, the one count, the
// leading-zero count or the trailing-zero count on an out_valid/out_ready port.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid, in_ready   input handshake (in_ready = block idle)
//   in, mode             word to scan; 00 zeros, 01 ones, 10 leading, 11 trailing
//   out_valid, out_ready output handshake
//   out                  OUT_W-bit result, held until taken
module zero_counter_seq #(
  parameter int unsigned IN_W    = 8,
  parameter int unsigned CHUNK_W = 2,
  parameter int unsigned OUT_W   = $clog2(IN_W + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out
);

  localparam int unsigned N     = IN_W / CHUNK_W;
  localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0] MODE_ZEROS = 2'b00;
  localparam logic [1:0] MODE_ONES  = 2'b01;
  localparam logic [1:0] MODE_LEAD  = 2'b10;

  if ((CHUNK_W < 1) || (CHUNK_W > IN_W) || ((IN_W % CHUNK_W) != 0)) begin : g_bad_param
    $error("zero_counter_seq: CHUNK_W must divide IN_W and satisfy 1 <= CHUNK_W <= IN_W");
  end

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;

  state_e             state_q, state_d;
  logic [IN_W-1:0]    word_q, word_d;
  logic [1:0]         mode_q, mode_d;
  logic [OUT_W-1:0]   acc_q, acc_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               stop_q, stop_d;

  logic               last_chunk;
  logic [IN_W-1:0]    in_rev;
  logic [OUT_W-1:0]   chunk_add;
  logic               hit;

  assign last_chunk = (idx_q == IDX_W'(N - 1));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)   state_d = RUN;
      RUN:     if (last_chunk) state_d = DONE;
      DONE:    if (out_ready)  state_d = IDLE;
      default:                 state_d = IDLE;
    endcase
  end

  // Outputs decoded from registered state and accumulator
  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    out       = acc_q;
  end

  // Bit-reversed input: leading-zero mode is stored reversed so every mode scans LSB-first
  always_comb begin
    in_rev = '0;
    for (int unsigned i = 0; i < IN_W; i++) begin
      in_rev[i] = in[IN_W - 1 - i];
    end
  end

  // Per-chunk contribution; hit carries the stop flag through the chunk in scan order
  always_comb begin
    chunk_add = '0;
    hit       = stop_q;
    for (int unsigned i = 0; i < CHUNK_W; i++) begin
      case (mode_q)
        MODE_ZEROS: if (!word_q[i]) chunk_add = chunk_add + OUT_W'(1);
        MODE_ONES:  if (word_q[i])  chunk_add = chunk_add + OUT_W'(1);
        default: begin
          if (!hit) begin
            if (word_q[i]) hit = 1'b1;
            else           chunk_add = chunk_add + OUT_W'(1);
          end
        end
      endcase
    end
  end

  // Datapath next-state: load on accept, shift/accumulate while running
  always_comb begin
    word_d = word_q;
    mode_d = mode_q;
    acc_d  = acc_q;
    idx_d  = idx_q;
    stop_d = stop_q;
    if ((state_q == IDLE) && in_valid) begin
      word_d = (mode == MODE_LEAD) ? in_rev : in;
      mode_d = mode;
      acc_d  = '0;
      idx_d  = '0;
      stop_d = 1'b0;
    end else if (state_q == RUN) begin
      word_d = IN_W'({{CHUNK_W{1'b0}}, word_q} >> CHUNK_W);
      acc_d  = acc_q + chunk_add;
      idx_d  = idx_q + IDX_W'(1);
      stop_d = hit;
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q <= '0;
      mode_q <= '0;
      acc_q  <= '0;
      idx_q  <= '0;
      stop_q <= 1'b0;
    end else begin
      word_q <= word_d;
      mode_q <= mode_d;
      acc_q  <= acc_d;
      idx_q  <= idx_d;
      stop_q <= stop_d;
    end
  end

endmodule

// File: tb/tb_zero_counter_seq.sv
module tb_zero_counter_seq;

  logic clk;
  logic rst_n;

  // Main instance: IN_W = 8, CHUNK_W = 2, N = 4
  logic       in_valid, in_ready, out_valid, out_ready;
  logic [7:0] din;
  logic [1:0] mode;
  logic [3:0] dout;

  // Sweep instances: 0 -> 8/1, 1 -> 8/8, 2 -> 12/3
  logic        sw_iv [3];
  logic        sw_ir [3];
  logic        sw_ov [3];
  logic        sw_or [3];
  logic [15:0] sw_in [3];
  logic [1:0]  sw_md [3];
  logic [3:0]  sw_out[3];

  int n_vec;
  int n_err;

  typedef struct {
    logic [7:0] word;
    logic [1:0] mode;
    logic [3:0] exp;
  } vec_t;

  vec_t vecs[18];

  zero_counter_seq #(.IN_W(8), .CHUNK_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in(din), .mode(mode), .out_valid(out_valid), .out_ready(out_ready), .out(dout)
  );

  zero_counter_seq #(.IN_W(8), .CHUNK_W(1)) dut_c1 (
    .clk(clk), .rst_n(rst_n), .in_valid(sw_iv[0]), .in_ready(sw_ir[0]),
    .in(sw_in[0][7:0]), .mode(sw_md[0]), .out_valid(sw_ov[0]), .out_ready(sw_or[0]),
    .out(sw_out[0])
  );

  zero_counter_seq #(.IN_W(8), .CHUNK_W(8)) dut_c8 (
    .clk(clk), .rst_n(rst_n), .in_valid(sw_iv[1]), .in_ready(sw_ir[1]),
    .in(sw_in[1][7:0]), .mode(sw_md[1]), .out_valid(sw_ov[1]), .out_ready(sw_or[1]),
    .out(sw_out[1])
  );

  zero_counter_seq #(.IN_W(12), .CHUNK_W(3)) dut_w12 (
    .clk(clk), .rst_n(rst_n), .in_valid(sw_iv[2]), .in_ready(sw_ir[2]),
    .in(sw_in[2][11:0]), .mode(sw_md[2]), .out_valid(sw_ov[2]), .out_ready(sw_or[2]),
    .out(sw_out[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Independent reference: counts directly on the original bit order
  function automatic int ref_model(input logic [15:0] w, input int width, input logic [1:0] m);
    int r;
    r = 0;
    case (m)
      2'b00: for (int i = 0; i < width; i++) if (!w[i]) r++;
      2'b01: for (int i = 0; i < width; i++) if (w[i]) r++;
      2'b10: for (int i = width - 1; i >= 0; i--) begin
               if (w[i]) break;
               r++;
             end
      default: for (int i = 0; i < width; i++) begin
                 if (w[i]) break;
                 r++;
               end
    endcase
    return r;
  endfunction

  // Send one word to the main instance (called at a negedge while idle), check latency and result
  task automatic run_main(input logic [7:0] w, input logic [1:0] m, input int exp, input string tag);
    int cyc;
    in_valid = 1'b1;
    din      = w;
    mode     = m;
    @(negedge clk);
    check({tag, "_in_ready_low"}, int'(in_ready), 0);
    in_valid = 1'b0;
    din      = 8'hA5;
    mode     = 2'b01;
    cyc      = 0;
    while (!out_valid && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "_latency"}, cyc, 4);
    check({tag, "_out"}, int'(dout), exp);
    @(negedge clk);
  endtask

  task automatic sweep_word(input int k, input int width, input int n,
                            input logic [15:0] w, input logic [1:0] m);
    int cyc;
    sw_iv[k] = 1'b1;
    sw_in[k] = w;
    sw_md[k] = m;
    @(negedge clk);
    sw_iv[k] = 1'b0;
    cyc      = 0;
    while (!sw_ov[k] && cyc < n + 8) begin
      @(negedge clk);
      cyc++;
    end
    check($sformatf("sweep%0d_lat_w%0h_m%0d", k, w, m), cyc, n);
    check($sformatf("sweep%0d_out_w%0h_m%0d", k, w, m), int'(sw_out[k]), ref_model(w, width, m));
    @(negedge clk);
  endtask

  task automatic sweep(input int k, input int width, input int n);
    logic [15:0] mask;
    logic [15:0] w;
    mask = (16'h1 << width) - 16'h1;
    for (int m = 0; m < 4; m++) begin
      for (int j = 0; j < 6; j++) begin
        if (j == 0)      w = 16'h0;
        else if (j == 1) w = mask;
        else             w = 16'($urandom) & mask;
        sweep_word(k, width, n, w, 2'(m));
      end
    end
  endtask

  initial begin
    int cyc;
    n_vec = 0;
    n_err = 0;

    vecs[0]  = '{8'b11110000, 2'b00, 4'd4};
    vecs[1]  = '{8'b11110000, 2'b01, 4'd4};
    vecs[2]  = '{8'b00100111, 2'b10, 4'd2};
    vecs[3]  = '{8'b00100111, 2'b11, 4'd0};
    vecs[4]  = '{8'b00100111, 2'b01, 4'd4};
    vecs[5]  = '{8'b00100111, 2'b00, 4'd4};
    vecs[6]  = '{8'b00000000, 2'b00, 4'd8};
    vecs[7]  = '{8'b00000000, 2'b10, 4'd8};
    vecs[8]  = '{8'b00000000, 2'b11, 4'd8};
    vecs[9]  = '{8'b00000000, 2'b01, 4'd0};
    vecs[10] = '{8'b11111111, 2'b00, 4'd0};
    vecs[11] = '{8'b11111111, 2'b10, 4'd0};
    vecs[12] = '{8'b11111111, 2'b11, 4'd0};
    vecs[13] = '{8'b11111111, 2'b01, 4'd8};
    vecs[14] = '{8'b00000111, 2'b10, 4'd5};
    vecs[15] = '{8'b10000000, 2'b11, 4'd7};
    vecs[16] = '{8'b00010000, 2'b10, 4'd3};
    vecs[17] = '{8'b00010000, 2'b11, 4'd4};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    din       = '0;
    mode      = '0;
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      sw_iv[k] = 1'b0;
      sw_in[k] = '0;
      sw_md[k] = '0;
      sw_or[k] = 1'b1;
    end

    // Reset state
    #12;
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out", int'(dout), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset asserted in the middle of a scan
    in_valid = 1'b1;
    din      = 8'b11110000;
    mode     = 2'b00;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrun_rst_out_valid", int'(out_valid), 0);
    check("midrun_rst_out", int'(dout), 0);
    check("midrun_rst_in_ready", int'(in_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check($sformatf("post_rst_no_stale_%0d", i), int'(out_valid), 0);
    end
    check("post_rst_in_ready", int'(in_ready), 1);

    // Directed vector table
    foreach (vecs[i]) begin
      run_main(vecs[i].word, vecs[i].mode, int'(vecs[i].exp), $sformatf("vec%0d", i));
    end

    // Backpressure: hold result while a new word waits
    out_ready = 1'b0;
    in_valid  = 1'b1;
    din       = 8'b11110000;
    mode      = 2'b01;
    @(negedge clk);
    in_valid = 1'b0;
    cyc      = 0;
    while (!out_valid && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check("bp_latency", cyc, 4);
    check("bp_out", int'(dout), 4);
    in_valid = 1'b1;
    din      = 8'b00000111;
    mode     = 2'b10;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("bp_hold_valid_%0d", i), int'(out_valid), 1);
      check($sformatf("bp_hold_out_%0d", i), int'(dout), 4);
      check($sformatf("bp_hold_in_ready_%0d", i), int'(in_ready), 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_valid", int'(out_valid), 0);
    check("bp_release_in_ready", int'(in_ready), 1);
    @(negedge clk);
    check("bp_new_accepted", int'(in_ready), 0);
    in_valid = 1'b0;
    cyc      = 0;
    while (!out_valid && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check("bp_new_latency", cyc, 4);
    check("bp_new_out", int'(dout), 5);
    @(negedge clk);

    // Parameter sweep against the reference model
    fork
      sweep(0, 8, 8);
      sweep(1, 8, 1);
      sweep(2, 12, 4);
    join

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
